uart_mmio_cpu: RTL and testbench
================================

// Module: uart_mmio_cpu
// PURPOSE
//  Single-cycle RV32I-subset core: instruction ROM, data RAM and a memory-mapped I/O page.
//  Drives a 16-bit hex-display register and hands bytes to an external UART transmitter
//  via a data byte plus a one-cycle start strobe. Top-level CPU of the UART/MMIO lab.
// PARAMETERS
//  ROM_FILE   "prog.hex"  $readmemh image for instruction ROM (one 32-bit word per line)
//  ROM_AW     8           ROM word-address bits (256 words)
//  RAM_AW     8           data RAM word-address bits (256 words)
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  data_out0    out  16  hex-display register (MMIO 0x8000_0000)
//  uart_data    out  8   byte for UART transmitter (MMIO 0x8000_0004)
//  uart_start   out  1   one-cycle strobe: uart_data valid, begin transmit
//  uart_busy    in   1   transmitter busy; readable at MMIO 0x8000_0008 bit0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - Reset (rst_n=0, async): pc=0, x1..x31=0, data_out0=0, uart_data=0, uart_start=0.
//    RAM contents not reset. Reset mid-instruction discards that instruction's writeback.
//  - One instruction per cycle; fetch rom[pc[ROM_AW+1:2]]; pc+4 unless branch/jump taken.
//    pc wraps modulo ROM size; misaligned target: low 2 bits ignored.
//  - Supported: LUI, ADDI, ADD, SUB, AND, OR, XOR, SLT, SLLI, SRLI, LW, SW, BEQ, BNE, BLT, JAL.
//    Any other opcode = NOP (pc+4, no writes). x0 reads 0, writes ignored.
//  - Arithmetic 32-bit two's complement, overflow wraps; SLT/BLT signed; shifts use imm[4:0].
//  - JAL: rd=pc+4, pc=pc+imm; branches: pc=pc+imm when taken (imm sign-extended, bit0=0).
//  - Address decode on bit31: 0 -> RAM (word addr = addr[RAM_AW+1:2], wraps); 1 -> MMIO.
//  - LW RAM: combinational read, result written to rd same cycle.
//  - SW RAM: written at clock edge; byte/half stores not supported.
//  - MMIO write 0x8000_0000: data_out0 <= rs2[15:0] at the edge.
//  - MMIO write 0x8000_0004: uart_data <= rs2[7:0], uart_start=1 for exactly the next cycle,
//    then 0. Back-to-back stores give back-to-back pulses.
//    Core does not check uart_busy; software polls 0x8000_0008 before writing.
//  - MMIO read 0x8000_0008 -> {31'b0, uart_busy}; 0x8000_0000 -> {16'b0, data_out0};
//    0x8000_0004 -> {24'b0, uart_data}. Other MMIO reads 0; writes ignored.
//  - Register file: 2 async read ports, 1 sync write port; rd write and same-cycle read
//    of that reg returns old value.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> data_out0=0, uart_start=0, pc=0; release -> fetch rom[0].
//  2 ADDI x1,x0,0x12; ADDI x2,x0,0x34; ADD x3,x1,x2; SW x3,0(x10=0x8000_0000)
//    -> data_out0=0x0046 after 4th edge.
//  3 ADDI x5,x0,0x41; SW x5,4(x10) -> uart_data=0x41, uart_start high exactly 1 cycle.
//  4 Poll loop: LW x6,8(x10); BNE x6,x0,-4 with uart_busy=1 for 5 cycles -> loop repeats,
//    exits the cycle after busy=0, then next SW emits single strobe.
//  5 RAM: SW 0x1234 to addr 0x10, LW back into x7, store x7 to display -> data_out0=0x1234.
//  6 Edge: ADDI x0,x0,5 then ADD x8,x0,x0 -> x8=0; 0x7FFF_FFFF+1 -> 0x8000_0000; unknown
//    opcode -> NOP; JAL x1,+8 -> x1=pc+4, next fetch pc+8.

Source files
------------

// File: rtl/uart_mmio_cpu.sv
// Single-cycle RV32I-subset core with instruction ROM, data RAM and
// an MMIO page driving a hex display register and a UART byte strobe.
module uart_mmio_cpu #(
  parameter string ROM_FILE = "prog.hex",
  parameter int    ROM_AW   = 8,
  parameter int    RAM_AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] data_out0,
  output logic [7:0]  uart_data,
  output logic        uart_start,
  input  logic        uart_busy
);

  localparam int PW = ROM_AW + 2;

  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [31:0] A_DISP  = 32'h8000_0000;
  localparam logic [31:0] A_UTX   = 32'h8000_0004;
  localparam logic [31:0] A_USTAT = 32'h8000_0008;

  logic [31:0] rom [2**ROM_AW];
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] rf_q [32];

  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;
  logic [PW-1:0] pc_plus4;
  logic [15:0]   disp_q;
  logic [7:0]    udata_q;
  logic          ustart_q;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign inst   = rom[pc_q[PW-1:2]];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};

  logic [31:0] rs1v;
  logic [31:0] rs2v;

  assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  logic [31:0]       addr;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       mmio_rd;
  logic [31:0]       ld_val;

  assign addr    = rs1v + ((opcode == OP_ST) ? imm_s : imm_i);
  assign ram_idx = addr[RAM_AW+1:2];

  always_comb begin
    mmio_rd = 32'd0;
    case (addr)
      A_DISP:  mmio_rd = {16'd0, disp_q};
      A_UTX:   mmio_rd = {24'd0, udata_q};
      A_USTAT: mmio_rd = {31'd0, uart_busy};
      default: mmio_rd = 32'd0;
    endcase
  end

  assign ld_val = addr[31] ? mmio_rd : ram[ram_idx];

  logic        wb_en;
  logic [31:0] wb_val;
  logic        st_en;
  logic        take;
  logic [31:0] off;
  logic [31:0] tgt;

  assign pc_plus4 = pc_q + PW'(4);

  always_comb begin
    wb_en  = 1'b0;
    wb_val = 32'd0;
    st_en  = 1'b0;
    take   = 1'b0;
    off    = imm_b;
    case (opcode)
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OP_IMM: begin
        case (f3)
          3'b000: begin
            wb_en  = 1'b1;
            wb_val = rs1v + imm_i;
          end
          3'b001: if (f7 == 7'h00) begin
            wb_en  = 1'b1;
            wb_val = rs1v << rs2;
          end
          3'b101: if (f7 == 7'h00) begin
            wb_en  = 1'b1;
            wb_val = rs1v >> rs2;
          end
          default: ;
        endcase
      end
      OP_REG: begin
        wb_en = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: wb_val = rs1v + rs2v;
          {7'h20, 3'b000}: wb_val = rs1v - rs2v;
          {7'h00, 3'b111}: wb_val = rs1v & rs2v;
          {7'h00, 3'b110}: wb_val = rs1v | rs2v;
          {7'h00, 3'b100}: wb_val = rs1v ^ rs2v;
          {7'h00, 3'b010}:
            wb_val = {31'd0, $signed(rs1v) < $signed(rs2v)};
          default: wb_en = 1'b0;
        endcase
      end
      OP_LD: if (f3 == 3'b010) begin
        wb_en  = 1'b1;
        wb_val = ld_val;
      end
      OP_ST: if (f3 == 3'b010) st_en = 1'b1;
      OP_BR: begin
        case (f3)
          3'b000:  take = (rs1v == rs2v);
          3'b001:  take = (rs1v != rs2v);
          3'b100:  take = ($signed(rs1v) < $signed(rs2v));
          default: take = 1'b0;
        endcase
      end
      OP_JAL: begin
        wb_en  = 1'b1;
        wb_val = 32'(pc_plus4);
        take   = 1'b1;
        off    = imm_j;
      end
      default: ;
    endcase
  end

  // Targets wrap modulo ROM size; the low two bits are dropped.
  assign tgt  = 32'(pc_q) + off;
  assign pc_d = take ? {tgt[PW-1:2], 2'b00} : pc_plus4;

  logic unused_ok;
  assign unused_ok = ^{tgt[31:PW], tgt[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      disp_q   <= '0;
      udata_q  <= '0;
      ustart_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      ustart_q <= st_en && (addr == A_UTX);
      if (wb_en && rd != 5'd0) rf_q[rd] <= wb_val;
      if (st_en && addr == A_DISP) disp_q <= rs2v[15:0];
      if (st_en && addr == A_UTX) udata_q <= rs2v[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && st_en && !addr[31]) ram[ram_idx] <= rs2v;
  end

  assign data_out0  = disp_q;
  assign uart_data  = udata_q;
  assign uart_start = ustart_q;

endmodule

// File: tb/tb_uart_mmio_cpu.sv
// Bench for uart_mmio_cpu: preloads programs into the ROM and scoreboards
// every display update and UART strobe against expected values.
module tb_uart_mmio_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uart_busy = 1'b0;
  logic [15:0] data_out0;
  logic [7:0]  uart_data;
  logic        uart_start;

  int n_cmp = 0;
  int n_bad = 0;
  int npulse = 0;

  logic [31:0] q_uart[$];
  logic [31:0] q_disp[$];
  logic [31:0] prog[$];
  logic [15:0] prev_disp = 16'd0;

  uart_mmio_cpu #(
    .ROM_FILE(""),
    .ROM_AW  (8),
    .RAM_AW  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_out0 (data_out0),
    .uart_data (uart_data),
    .uart_start(uart_start),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(string tag, logic [31:0] got,
                           logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lui(logic [4:0] rd,
                                      logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1,
                                       logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] shi(logic [2:0] f3, logic [4:0] rd,
                                      logic [4:0] rs1, logic [4:0] sh);
    return {7'h00, sh, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] rr(logic [6:0] f7, logic [2:0] f3,
                                     logic [4:0] rd, logic [4:0] rs1,
                                     logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1,
                                     logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'h03};
  endfunction

  function automatic logic [31:0] sw(logic [4:0] rs2, logic [4:0] rs1,
                                     logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] br(logic [2:0] f3, logic [4:0] rs1,
                                     logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      dut.rom[8'(i)] = (i < prog.size()) ? prog[i] : 32'h0000_006F;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_disp = 16'd0;
    end else begin
      if (uart_start) begin
        npulse++;
        if (q_uart.size() == 0) expect_eq("uart_extra", 32'(uart_data), 32'hFFFF_FFFF);
        else expect_eq("uart", 32'(uart_data), q_uart.pop_front());
      end
      if (data_out0 != prev_disp) begin
        if (q_disp.size() == 0) expect_eq("disp_extra", 32'(data_out0), 32'hFFFF_FFFF);
        else expect_eq("disp", 32'(data_out0), q_disp.pop_front());
        prev_disp = data_out0;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    expect_eq("rst_pc", 32'(dut.pc_q), 32'd0);
    expect_eq("rst_disp", 32'(data_out0), 32'd0);
    expect_eq("rst_udata", 32'(uart_data), 32'd0);
    expect_eq("rst_ustart", 32'(uart_start), 32'd0);

    prog.delete();
    prog.push_back(lui(5'd10, 20'h80000));
    prog.push_back(addi(5'd1, 5'd0, 12'h012));
    prog.push_back(addi(5'd2, 5'd0, 12'h034));
    prog.push_back(rr(7'h00, 3'b000, 5'd3, 5'd1, 5'd2));
    prog.push_back(sw(5'd3, 5'd10, 12'h000));
    prog.push_back(addi(5'd5, 5'd0, 12'h041));
    prog.push_back(sw(5'd5, 5'd10, 12'h004));
    prog.push_back(addi(5'd0, 5'd0, 12'h005));
    prog.push_back(rr(7'h00, 3'b000, 5'd8, 5'd0, 5'd0));
    prog.push_back(addi(5'd9, 5'd0, 12'h077));
    prog.push_back(rr(7'h00, 3'b000, 5'd9, 5'd9, 5'd8));
    prog.push_back(sw(5'd9, 5'd10, 12'h000));
    prog.push_back(lui(5'd11, 20'h80000));
    prog.push_back(addi(5'd11, 5'd11, 12'hFFF));
    prog.push_back(addi(5'd11, 5'd11, 12'h001));
    prog.push_back(shi(3'b101, 5'd12, 5'd11, 5'd16));
    prog.push_back(sw(5'd12, 5'd10, 12'h000));
    prog.push_back(32'h0000_060B);
    prog.push_back({12'h001, 5'd12, 3'b010, 5'd12, 7'h13});
    prog.push_back(addi(5'd13, 5'd12, 12'h001));
    prog.push_back(sw(5'd13, 5'd10, 12'h000));
    prog.push_back(jal(5'd1, 21'h8));
    prog.push_back(addi(5'd15, 5'd0, 12'h0EE));
    prog.push_back(sw(5'd1, 5'd10, 12'h000));
    prog.push_back(sw(5'd15, 5'd10, 12'h004));
    prog.push_back(addi(5'd16, 5'd0, 12'hFFD));
    prog.push_back(addi(5'd17, 5'd0, 12'h005));
    prog.push_back(rr(7'h00, 3'b010, 5'd18, 5'd16, 5'd17));
    prog.push_back(rr(7'h20, 3'b000, 5'd19, 5'd17, 5'd16));
    prog.push_back(shi(3'b001, 5'd20, 5'd19, 5'd4));
    prog.push_back(rr(7'h00, 3'b110, 5'd20, 5'd20, 5'd18));
    prog.push_back(sw(5'd20, 5'd10, 12'h004));
    prog.push_back(rr(7'h00, 3'b100, 5'd21, 5'd16, 5'd17));
    prog.push_back(addi(5'd22, 5'd0, 12'h7F0));
    prog.push_back(rr(7'h00, 3'b111, 5'd21, 5'd21, 5'd22));
    prog.push_back(sw(5'd21, 5'd10, 12'h000));
    prog.push_back(br(3'b100, 5'd16, 5'd17, 13'h0008));
    prog.push_back(sw(5'd17, 5'd10, 12'h004));
    prog.push_back(br(3'b100, 5'd17, 5'd16, 13'h0008));
    prog.push_back(addi(5'd23, 5'd0, 12'h03C));
    prog.push_back(br(3'b000, 5'd0, 5'd0, 13'h0008));
    prog.push_back(addi(5'd23, 5'd0, 12'h099));
    prog.push_back(sw(5'd23, 5'd10, 12'h004));
    prog.push_back(jal(5'd0, 21'h0));
    load_prog();
    q_disp = '{32'h0046, 32'h0077, 32'h8000, 32'h8001,
               32'h0058, 32'h07F0};
    q_uart = '{32'h41, 32'h00, 32'h81, 32'h3C};
    npulse = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(60);
    expect_eq("A_disp_left", 32'(q_disp.size()), 32'd0);
    expect_eq("A_uart_left", 32'(q_uart.size()), 32'd0);
    expect_eq("A_pulses", 32'(npulse), 32'd4);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("arst_disp", 32'(data_out0), 32'd0);
    expect_eq("arst_udata", 32'(uart_data), 32'd0);
    expect_eq("arst_pc", 32'(dut.pc_q), 32'd0);
    cyc(2);

    prog.delete();
    prog.push_back(lui(5'd10, 20'h80000));
    prog.push_back(lw(5'd6, 5'd10, 12'h008));
    prog.push_back(br(3'b001, 5'd6, 5'd0, 13'h1FFC));
    prog.push_back(addi(5'd5, 5'd0, 12'h05A));
    prog.push_back(sw(5'd5, 5'd10, 12'h004));
    prog.push_back(sw(5'd5, 5'd10, 12'h004));
    prog.push_back(lui(5'd20, 20'h00001));
    prog.push_back(addi(5'd20, 5'd20, 12'h234));
    prog.push_back(sw(5'd20, 5'd0, 12'h010));
    prog.push_back(lw(5'd7, 5'd0, 12'h010));
    prog.push_back(sw(5'd7, 5'd10, 12'h000));
    prog.push_back(lw(5'd8, 5'd10, 12'h000));
    prog.push_back(addi(5'd8, 5'd8, 12'h001));
    prog.push_back(sw(5'd8, 5'd10, 12'h000));
    prog.push_back(lw(5'd9, 5'd10, 12'h004));
    prog.push_back(addi(5'd9, 5'd9, 12'h001));
    prog.push_back(sw(5'd9, 5'd10, 12'h004));
    prog.push_back(jal(5'd0, 21'h0));
    load_prog();
    q_disp = '{32'h1234, 32'h1235};
    q_uart = '{32'h5A, 32'h5A, 32'h5B};
    npulse = 0;
    uart_busy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(12);
    expect_eq("poll_hold", 32'(npulse), 32'd0);
    expect_eq("poll_pc",
              32'(dut.pc_q == 10'd4 || dut.pc_q == 10'd8), 32'd1);
    uart_busy = 1'b0;
    begin
      int k = 0;
      while (npulse == 0 && k < 10) begin
        cyc(1);
        k++;
      end
      expect_eq("poll_exit", 32'(npulse != 0), 32'd1);
    end
    cyc(30);
    expect_eq("B_disp_left", 32'(q_disp.size()), 32'd0);
    expect_eq("B_uart_left", 32'(q_uart.size()), 32'd0);
    expect_eq("B_pulses", 32'(npulse), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
